// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - state encoding and grant ids shared by mem_arbiter and arb_pick
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_e;

  localparam logic GNT_INST = 1'b0;
  localparam logic GNT_DATA = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational grant select; MEM_ARB_RR_EN selects round-robin on conflict
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic inst_req,
  input  logic data_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    grant_valid = inst_req | data_req;
    grant_id    = data_req ? GNT_DATA : GNT_INST;
    // On conflict the port that did not win last time goes next
    if (inst_req && data_req) begin
      grant_id = ~last_grant;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_valid = inst_req | data_req;
    grant_id    = data_req ? GNT_DATA : GNT_INST;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data to single-port RAM arbiter, issue then response; MEM_ARB_RR_EN enables round-robin
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clka,
  input  logic          rst,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  output logic [DW-1:0] inst_rdata,
  output logic          inst_ack,
  input  logic          data_req,
  input  logic          data_we,
  input  logic [3:0]    data_be,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          data_ack,
  output logic          ram_en,
  output logic [3:0]    ram_wea,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          run_q;
  logic          data_we_q;
  logic [DW-1:0] inst_rdata_q;
  logic [DW-1:0] data_rdata_q;
  logic          grant_valid;
  logic          grant_id;
  logic          issue;

  arb_pick u_pick (
    .inst_req    (inst_req),
    .data_req    (data_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // run_q keeps the RAM quiet for the cycle right after a reset edge
  assign issue = (state_q == IDLE) && run_q && grant_valid;

  always_comb begin
    state_d      = IDLE;
    last_grant_d = last_grant_q;
    ram_en       = 1'b0;
    ram_wea      = 4'h0;
    ram_addr     = '0;
    ram_din      = '0;
    if (issue) begin
      ram_en       = 1'b1;
      last_grant_d = grant_id;
      if (grant_id == GNT_DATA) begin
        ram_wea  = data_we ? data_be : 4'h0;
        ram_addr = data_addr;
        ram_din  = data_wdata;
        state_d  = RESP_D;
      end else begin
        ram_addr = inst_addr;
        state_d  = RESP_I;
      end
    end
  end

  always_ff @(posedge clka) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_INST;
      run_q        <= 1'b0;
      data_we_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      run_q        <= 1'b1;
      if (issue) begin
        data_we_q <= data_we && (grant_id == GNT_DATA);
      end
      if (state_q == RESP_I) begin
        inst_rdata_q <= ram_dout;
      end
      if ((state_q == RESP_D) && !data_we_q) begin
        data_rdata_q <= ram_dout;
      end
    end
  end

  assign inst_ack = (state_q == RESP_I);
  assign data_ack = (state_q == RESP_D);

  // RAM data arrives during the ack cycle, so it is forwarded then and held from the register afterwards
  assign inst_rdata = inst_ack ? ram_dout : inst_rdata_q;
  assign data_rdata = (data_ack && !data_we_q) ? ram_dout : data_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port-to-one memory arbiter that lets the MIPS instruction-fetch port and data-access port share a single synchronous single-port RAM (1-cycle read latency, 32-bit words, 4 byte-write enables). It sits between the `mips` core and a unified memory. It selects one requester per access and drives the RAM. It returns the read data with a one-cycle ack pulse. Each access takes two cycles: issue, then response.

## Interface
Parameters:
- `AW`, 32, address width (byte address, passed through unchanged)
- `DW`, 32, data width

Ports:
- `clka` in 1: the single clock; all state updates on the rising edge
- `rst` in 1: synchronous, active-low reset
- `inst_req` in 1: fetch request, held high until `inst_ack`
- `inst_addr` in AW: fetch address, stable while `inst_req` is high
- `inst_rdata` out DW: fetch data, valid while `inst_ack` is high, held afterwards
- `inst_ack` out 1: one-cycle completion pulse
- `data_req` in 1: data request, held until `data_ack`
- `data_we` in 1: 1 = write, 0 = read
- `data_be` in 4: byte enables for writes
- `data_addr` in AW: data address
- `data_wdata` in DW: write data
- `data_rdata` out DW: read data, valid with `data_ack`, held afterwards
- `data_ack` out 1: one-cycle completion pulse for reads and writes
- `ram_en` out 1: RAM enable
- `ram_wea` out 4: RAM byte write enables
- `ram_addr` out AW: RAM address
- `ram_din` out DW: RAM write data
- `ram_dout` in DW: RAM read data, one cycle after the `ram_en` cycle

## Operation
State machine (`state`): IDLE, RESP_I, RESP_D.

IDLE:
- Requests are sampled only in this state.
- If no request is pending, the RAM outputs are all zero.
- If a request is pending, the grant is chosen combinationally and the RAM outputs are driven from the granted port in the same cycle:
  - `ram_en`=1
  - `ram_wea` = `data_we` ? `data_be` : 0 for a data grant; 0 for an instruction grant
- Next state is RESP_I or RESP_D.
- Conflict (both requests high): the data port wins by default; see Configuration.

RESP_I / RESP_D:
- The RAM outputs are zero.
- The matching ack pulses to 1.
- The matching rdata register loads `ram_dout`. On a write ack, `data_rdata` keeps its old value.
- The block unconditionally returns to IDLE.

Once issued, an access always completes. A request dropped before its ack is still acked.

After an ack, the requester may keep its req high to start a new access, which is sampled in the next IDLE cycle. It may also lower req.

`last_grant` is a 1-bit register recording the port most recently granted.

## Timing
- Reset (`rst`=0 at an edge) puts the block in:
  - `state`=IDLE
  - `inst_ack`=`data_ack`=0
  - `inst_rdata`=`data_rdata`=0
  - `last_grant`=INST
  - RAM outputs 0 from the next cycle
- A reset during RESP_x aborts that ack. A write already issued in IDLE is not undone.
- Latency: the request is seen in IDLE in cycle N, the RAM is enabled in cycle N, and the ack occurs in cycle N+1.
- Throughput: at most one access per two cycles. Under continuous contention in fixed mode, fetch is starved.
- The acks are mutually exclusive, and neither is ever high in IDLE.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin on conflict. The grant goes to the port that is not `last_grant`.
- `MEM_ARB_RR_EN` undefined: fixed priority, data always wins on conflict. `last_grant` is still maintained but unused.
- Non-conflict behaviour is identical in both modes.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, RESP_I, RESP_D)
  - the grant constants `GNT_INST`=0 and `GNT_DATA`=1
- Sub-module `arb_pick`: combinational grant select. Inputs are the two requests and `last_grant`; outputs are `grant_valid` and `grant_id`. It holds the macro-dependent logic.

## Test plan
- Fetch only: `inst_req`=1, `inst_addr`=0x04, `ram_dout`=0x2008000A in cycle N+1. Expect `ram_en`=1 with `ram_addr`=0x04 in cycle N, then `inst_ack`=1 and `inst_rdata`=0x2008000A in N+1.
- Data write: `data_we`=1, `data_be`=0xF, `data_addr`=0x50, `data_wdata`=0xDEADBEEF. Expect `ram_wea`=0xF and `ram_din`=0xDEADBEEF in N, `data_ack` in N+1, and `data_rdata` unchanged.
- Conflict, fixed mode: both requests held for 8 cycles. Expect 4 data acks and 0 instruction acks.
- Conflict, `MEM_ARB_RR_EN` defined: the same stimulus gives alternating acks D, I, D, I.
- Reset in RESP_D: `rst`=0 at that edge. Expect no `data_ack`, `data_rdata`=0, state IDLE, and a pending request reissued after `rst`=1.
- Dropped request: `data_req` lowered in RESP_D. Expect `data_ack` still 1 that cycle, then no RAM activity in the following IDLE.
